program_memory_loader: RTL and testbench

PROGRAM_MEMORY_LOADER -- requirements
Module: program_memory_loader

---
 rtl/program_memory_loader.sv | 132 +++++++++++++
 tb/tb_program_memory_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - byte-serial program image loader with word-fetch port
//
// Purpose: receives a byte stream, packs it big-endian into words and writes
// them into an instruction memory. Supports registered instruction fetch by
// byte address while idle.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   Address, Fetch        fetch byte address and request
//   Instruction           registered fetched word (0 on address error)
//   InstrValid            1-cycle pulse per accepted fetch
//   AddrError             fetched address misaligned or out of range
//   LoadStart, LoadEnd    begin / terminate an image load
//   LoadByte, LoadByteValid  image byte and qualifier
//   LoadReady             loader accepts a byte this cycle
//   LoadDone              1-cycle pulse when a load finishes
//   WordCount             words written by the current/last load
module program_memory_loader #(
   parameter int                    MEMORY_DEPTH = 64,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_WIDTH-1:0]           Address,
   input  logic                            Fetch,
   output logic [DATA_WIDTH-1:0]           Instruction,
   output logic                            InstrValid,
   output logic                            AddrError,
   input  logic                            LoadStart,
   input  logic                            LoadEnd,
   input  logic [7:0]                      LoadByte,
   input  logic                            LoadByteValid,
   output logic                            LoadReady,
   output logic                            LoadDone,
   output logic [$clog2(MEMORY_DEPTH):0]   WordCount
);

   localparam int AW = $clog2(MEMORY_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, LOADING} state_t;

   state_t                  state;
   logic [1:0]              byte_count;
   logic [31:0]             assembly;
   logic [DATA_WIDTH-1:0]   mem [MEMORY_DEPTH];

   logic [DATA_WIDTH-1:0]   offset;
   logic [DATA_WIDTH-3:0]   index;
   logic [AW-1:0]           read_index;
   logic                    addr_bad;
   logic [31:0]             next_assembly;
   logic                    write_word;
   logic                    last_word;
   logic                    unused_bits;

   // Fetch address decode; wrap-around of the subtraction below the base is
   // caught by the explicit Address < BASE_ADDRESS term.
   assign offset     = Address - BASE_ADDRESS;
   assign index      = offset[DATA_WIDTH-1:2];
   assign read_index = index[AW-1:0];
   assign addr_bad   = (Address[1:0] != 2'b00) ||
                       (Address < BASE_ADDRESS) ||
                       (index >= (DATA_WIDTH-2)'(MEMORY_DEPTH));

   // Low offset bits only matter through Address[1:0]; the top assembly byte
   // is shifted out before it is ever consumed.
   assign unused_bits = ^{offset[1:0], assembly[31:24]};

   assign next_assembly = {assembly[23:0], LoadByte};
   assign write_word    = !reset && (state == LOADING) && LoadByteValid && (byte_count == 2'd3);
   assign last_word     = (WordCount == CW'(MEMORY_DEPTH - 1));
   assign LoadReady     = (state == LOADING);

   // Memory is deliberately outside the reset domain so an image survives reset.
   always_ff @(posedge clk) begin
      if (write_word) begin
         mem[WordCount[AW-1:0]] <= DATA_WIDTH'(next_assembly);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         byte_count  <= 2'd0;
         assembly    <= 32'd0;
         WordCount   <= '0;
         Instruction <= '0;
         InstrValid  <= 1'b0;
         AddrError   <= 1'b0;
         LoadDone    <= 1'b0;
      end else begin
         InstrValid <= 1'b0;
         AddrError  <= 1'b0;
         LoadDone   <= 1'b0;
         case (state)
            IDLE: begin
               if (Fetch) begin
                  InstrValid  <= 1'b1;
                  AddrError   <= addr_bad;
                  Instruction <= addr_bad ? '0 : mem[read_index];
               end
               if (LoadStart) begin
                  state      <= LOADING;
                  WordCount  <= '0;
                  byte_count <= 2'd0;
                  assembly   <= 32'd0;
               end
            end
            LOADING: begin
               if (LoadByteValid) begin
                  assembly   <= next_assembly;
                  byte_count <= byte_count + 2'd1;
               end
               if (write_word) begin
                  WordCount <= WordCount + CW'(1);
               end
               // Completing the last word ends the load so the pointer never wraps.
               if (LoadEnd || (write_word && last_word)) begin
                  state      <= IDLE;
                  LoadDone   <= 1'b1;
                  byte_count <= 2'd0;
                  assembly   <= 32'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_memory_loader.sv
// tb/tb_program_memory_loader.sv - self-checking bench for program_memory_loader
module tb_program_memory_loader;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic        Fetch;
   logic [31:0] Instruction;
   logic        InstrValid;
   logic        AddrError;
   logic        LoadStart;
   logic        LoadEnd;
   logic [7:0]  LoadByte;
   logic        LoadByteValid;
   logic        LoadReady;
   logic        LoadDone;
   logic [6:0]  WordCount;

   int          tests    = 0;
   int          failures = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] last_instr;

   program_memory_loader #(
      .MEMORY_DEPTH(DEPTH),
      .DATA_WIDTH(32),
      .BASE_ADDRESS(BASE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .Address(Address),
      .Fetch(Fetch),
      .Instruction(Instruction),
      .InstrValid(InstrValid),
      .AddrError(AddrError),
      .LoadStart(LoadStart),
      .LoadEnd(LoadEnd),
      .LoadByte(LoadByte),
      .LoadByteValid(LoadByteValid),
      .LoadReady(LoadReady),
      .LoadDone(LoadDone),
      .WordCount(WordCount)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      Fetch = 1'b0; LoadStart = 1'b0; LoadEnd = 1'b0; LoadByteValid = 1'b0;
      LoadByte = 8'h00; Address = 32'h0;
      tick;
      tick;
      reset = 1'b0;
      last_instr = 32'h0;
   endtask

   // Drive one complete load and compare against the byte-stream rules:
   // words = floor(bytes/4) capped at DEPTH, big-endian packing, one LoadDone.
   task automatic run_load(input logic [7:0] bytes[$], input bit end_with_last, input string tag);
      int accepted = 0;
      int done_cnt = 0;
      int n        = bytes.size();
      int exp_words;
      LoadStart = 1'b1; LoadByteValid = 1'b1; LoadByte = 8'($urandom);
      tick;
      LoadStart = 1'b0; LoadByteValid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(3) == 0) begin
            LoadByte  = 8'($urandom);
            LoadStart = (accepted < 4*DEPTH) ? 1'($urandom_range(1)) : 1'b0;
            check({tag, " ready_gap"}, LoadReady, accepted < 4*DEPTH);
            tick;
            LoadStart = 1'b0;
            done_cnt += int'(LoadDone);
         end
         check({tag, " ready"}, LoadReady, accepted < 4*DEPTH);
         LoadByteValid = 1'b1;
         LoadByte      = bytes[i];
         LoadEnd       = end_with_last && (i == n-1);
         tick;
         LoadByteValid = 1'b0;
         LoadEnd       = 1'b0;
         done_cnt += int'(LoadDone);
         accepted++;
      end
      if (!end_with_last || n == 0) begin
         LoadEnd = 1'b1;
         tick;
         LoadEnd = 1'b0;
         done_cnt += int'(LoadDone);
      end
      tick;
      done_cnt += int'(LoadDone);
      exp_words = (n/4 < DEPTH) ? n/4 : DEPTH;
      for (int w = 0; w < exp_words; w++)
         model_mem[w] = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " word_count"}, WordCount, exp_words);
      check({tag, " ready_after"}, LoadReady, 0);
   endtask

   task automatic do_fetch(input logic [31:0] a, input string tag);
      logic [31:0] ed;
      logic        ee;
      longint      off;
      off = longint'(a) - longint'(BASE);
      if (a[1:0] != 2'b00 || off < 0 || (off / 4) >= DEPTH) begin
         ed = 32'h0; ee = 1'b1;
      end else begin
         ed = model_mem[int'(off / 4)]; ee = 1'b0;
      end
      Address = a;
      Fetch   = 1'b1;
      tick;
      Fetch   = 1'b0;
      Address = $urandom;
      check({tag, " valid"}, InstrValid, 1);
      check({tag, " err"}, AddrError, ee);
      check({tag, " instr"}, Instruction, ed);
      last_instr = ed;
      tick;
      check({tag, " valid_drop"}, InstrValid, 0);
      check({tag, " err_drop"}, AddrError, 0);
      check({tag, " instr_hold"}, Instruction, last_instr);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(3))
         0:       return BASE + 4*$urandom_range(DEPTH-1);
         1:       return BASE + 4*$urandom_range(DEPTH-1) + $urandom_range(1, 3);
         2:       return BASE - 4*$urandom_range(1, 1000);
         default: return BASE + 4*DEPTH + 4*$urandom_range(0, 1000);
      endcase
   endfunction

   initial begin
      logic [7:0] q[$];
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

      // Reset state
      do_reset;
      check("rst instr", Instruction, 0);
      check("rst valid", InstrValid, 0);
      check("rst err", AddrError, 0);
      check("rst done", LoadDone, 0);
      check("rst count", WordCount, 0);
      check("rst ready", LoadReady, 0);

      // Full image with four surplus bytes
      q = {};
      for (int i = 0; i < 4*DEPTH + 4; i++) q.push_back(8'($urandom));
      run_load(q, 1'b0, "full");
      do_fetch(BASE + 4*(DEPTH-1), "full_last");
      do_fetch(BASE, "full_first");
      for (int i = 0; i < 4; i++) do_fetch(BASE + 4*$urandom_range(DEPTH-1), "full_rand");

      // Directed two-word load
      q = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load(q, 1'b0, "two");
      do_fetch(BASE, "two_w0");
      check("two_const", last_instr, 32'h2402_0005);
      do_fetch(BASE + 4, "two_w1");

      // Address errors
      do_fetch(32'h0040_0002, "err_misalign");
      do_fetch(32'h003F_FFFC, "err_below");
      do_fetch(BASE + 4*DEPTH, "err_above");

      // Partial word is discarded
      q = '{8'hAA, 8'hBB, 8'hCC};
      run_load(q, 1'b0, "partial");
      do_fetch(BASE, "partial_w0");

      // LoadEnd on the 4th byte still writes the word
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      run_load(q, 1'b1, "end4th");
      do_fetch(BASE + 4, "end4th_w1");

      // Reset mid-load after six bytes
      q = {};
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
      LoadStart = 1'b1;
      tick;
      LoadStart = 1'b0;
      for (int i = 0; i < 6; i++) begin
         LoadByteValid = 1'b1; LoadByte = q[i];
         tick;
      end
      LoadByteValid = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("rstload ready", LoadReady, 0);
      check("rstload done", LoadDone, 0);
      check("rstload count", WordCount, 0);
      check("rstload instr", Instruction, 0);
      last_instr = 32'h0;
      model_mem[0] = {q[0], q[1], q[2], q[3]};
      tick;
      check("rstload done_late", LoadDone, 0);
      do_fetch(BASE, "rstload_w0");
      do_fetch(BASE + 4, "rstload_w1");

      // Fetch while loading is ignored
      LoadStart = 1'b1;
      tick;
      LoadStart = 1'b0;
      Address = BASE; Fetch = 1'b1;
      tick;
      Fetch = 1'b0;
      check("ldfetch valid", InstrValid, 0);
      check("ldfetch err", AddrError, 0);
      check("ldfetch instr", Instruction, last_instr);
      LoadEnd = 1'b1;
      tick;
      LoadEnd = 1'b0;
      check("ldfetch done", LoadDone, 1);
      check("ldfetch count", WordCount, 0);
      tick;

      // Random loads and fetches
      for (int r = 0; r < 10; r++) begin
         q = {};
         for (int i = 0, n = $urandom_range(0, 40); i < n; i++) q.push_back(8'($urandom));
         run_load(q, 1'($urandom_range(1)), "rand_load");
         for (int f = 0; f < 4; f++) do_fetch(rand_addr(), "rand_fetch");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
